// File: rtl/candy_avb_mdio_pkg.sv
// candy_avb_mdio_pkg: shared state encodings, register offsets and MDIO frame constants
package candy_avb_mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] A_CMD     = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_RDATA   = 2'd2;
    localparam logic [1:0] A_IRQ_CTL = 2'd3;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] ST    = 2'b01;

    // 14-bit Clause 22 header: ST, OP, PHYAD, REGAD, sent MSB first
    function automatic logic [13:0] mdio_hdr(input logic rd, input logic [4:0] phy, input logic [4:0] regad);
        return {ST, rd ? OP_RD : OP_WR, phy, regad};
    endfunction

endpackage

// File: rtl/candy_avb_mdio_clkgen.sv
// candy_avb_mdio_clkgen: MDC divider producing mdc plus one-clk rise/fall tick pulses
//   clk, reset_n : system clock, async active-low reset
//   i_en         : run divider; when low counter and mdc are held at 0
//   o_mdc        : management clock
//   o_rise/o_fall: pulse in the clk cycle whose closing edge raises/lowers mdc
module candy_avb_mdio_clkgen
    import candy_avb_mdio_pkg::*;
#(
    parameter int CLK_DIV = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_mdc,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_mdc;
    logic       w_tc;

    assign w_tc   = i_en && (r_cnt == 8'(CLK_DIV));
    assign o_rise = w_tc && !r_mdc;
    assign o_fall = w_tc && r_mdc;
    assign o_mdc  = r_mdc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_mdc <= !r_mdc;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/candy_avb_mdio_master.sv
// candy_avb_mdio_master: Avalon-MM slave serializing Clause 22 MDIO frames onto mdc/mdio
//   clk, reset_n        : system clock, async active-low reset
//   address, chipselect, write_n, writedata, readdata : Avalon-MM slave (readdata registered)
//   mdc, mdio           : PHY management pins (mdio released to Z when not driving)
//   irq                 : done & irq_en, only when CANDY_AVB_MDIO_IRQ_EN is defined
module candy_avb_mdio_master
    import candy_avb_mdio_pkg::*;
#(
    parameter int CLK_DIV      = 24,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mdc,
    inout  wire         mdio
`ifdef CANDY_AVB_MDIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_t      r_state, w_state_nxt, w_next;
    logic [5:0]  r_bit, w_bit_nxt;
    logic        r_rd;
    logic [4:0]  r_phy, r_regad;
    logic [15:0] r_wdata, r_shift, r_rdata;
    logic        r_done;
    logic [31:0] r_readdata;
    logic        w_wr, w_accept, w_w1c, w_busy, w_last, w_oe, w_out, w_rise, w_fall, w_irq_ctl;
    logic [13:0] w_hdr;
    logic        w_unused;

    assign w_wr     = chipselect && !write_n;
    assign w_accept = w_wr && (address == A_CMD) && (r_state == S_IDLE);
    assign w_w1c    = w_wr && (address == A_STATUS) && writedata[1];
    assign w_busy   = r_state != S_IDLE;
    assign w_hdr    = mdio_hdr(r_rd, r_phy, r_regad);
    assign w_unused = ^writedata[31:27];

    assign w_last = (r_state == S_PRE) ? (r_bit == 6'(PREAMBLE_LEN - 1)) :
                    (r_state == S_HDR) ? (r_bit == 6'd13) :
                    (r_state == S_TA)  ? (r_bit == 6'd1)  : (r_bit == 6'd15);
    assign w_next = (r_state == S_PRE) ? S_HDR :
                    (r_state == S_HDR) ? S_TA  :
                    (r_state == S_TA)  ? S_DATA : S_DONE;

    candy_avb_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .reset_n(reset_n),
        .i_en   (w_busy && (r_state != S_DONE)),
        .o_mdc  (mdc),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Each bit is presented from one MDC falling edge (or frame start) to the next falling edge
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_oe        = 1'b0;
        w_out       = 1'b1;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (PREAMBLE_LEN == 0) ? S_HDR : S_PRE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: if (w_fall) begin
                w_bit_nxt   = w_last ? 6'd0 : r_bit + 6'd1;
                w_state_nxt = w_last ? w_next : r_state;
            end
        endcase
        w_oe  = (r_state == S_PRE) || (r_state == S_HDR) ||
                (!r_rd && ((r_state == S_TA) || (r_state == S_DATA)));
        w_out = (r_state == S_HDR)  ? w_hdr[4'd13 - r_bit[3:0]] :
                (r_state == S_TA)   ? (r_bit == 6'd0) :
                (r_state == S_DATA) ? r_wdata[4'd15 - r_bit[3:0]] : 1'b1;
    end

    assign mdio = w_oe ? w_out : 1'bz;

`ifdef CANDY_AVB_MDIO_IRQ_EN
    logic r_irq_en, r_irq;
    assign w_irq_ctl = r_irq_en;
    assign irq       = r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (address == A_IRQ_CTL)) r_irq_en <= writedata[0];
            r_irq <= r_done && r_irq_en;
        end
    end
`else
    assign w_irq_ctl = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bit      <= '0;
            r_rd       <= 1'b0;
            r_phy      <= '0;
            r_regad    <= '0;
            r_wdata    <= '0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            if (w_accept) {r_rd, r_phy, r_regad, r_wdata} <= writedata[26:0];
            if (w_rise && (r_state == S_DATA)) r_shift <= {r_shift[14:0], mdio};
            if ((r_state == S_DONE) && r_rd) r_rdata <= r_shift;
            // completion beats a same-cycle W1C
            r_done     <= (r_state == S_DONE) ? 1'b1 : (w_accept || w_w1c) ? 1'b0 : r_done;
            r_readdata <= (address == A_STATUS)  ? {30'd0, r_done, w_busy} :
                          (address == A_RDATA)   ? {16'd0, r_rdata} :
                          (address == A_IRQ_CTL) ? {31'd0, w_irq_ctl} : 32'd0;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_candy_avb_mdio_master.sv
// tb_candy_avb_mdio_master: directed + randomized frames checked against a bit-level frame model
module tb_candy_avb_mdio_master;

    localparam int CD  = 1;
    localparam int P   = 32;
    localparam int N   = P + 32;
    localparam int LAT = 2 * (CD + 1) * N + 2;
    localparam logic [1:0] A_CMD = 2'd0, A_STATUS = 2'd1, A_RDATA = 2'd2, A_IRQ = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    wire  [31:0] readdata;
    wire         mdc;
    wire         mdio;
`ifdef CANDY_AVB_MDIO_IRQ_EN
    wire         irq;
`endif

    logic        phy_oe = 1'b0, phy_bit = 1'b0, phy_rd = 1'b0;
    logic [15:0] phy_data = 16'd0;
    logic [15:0] ref_rdata = 16'd0;
    logic [31:0] rd;
    int          mon_q[$];
    int          exp_q[$];
    int          n_cmp = 0, n_bad = 0, lat;

    candy_avb_mdio_master #(.CLK_DIV(CD), .PREAMBLE_LEN(P)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .mdc       (mdc),
        .mdio      (mdio)
`ifdef CANDY_AVB_MDIO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    assign mdio = phy_oe ? phy_bit : 1'bz;

    always #5 clk = ~clk;

    // Bus monitor: record the line at every MDC rising edge (2 = released)
    always @(posedge mdc) mon_q.push_back((mdio === 1'bz) ? 2 : (mdio ? 1 : 0));

    // PHY model: drives read data after falling edges, for frame bit positions P+16..P+31
    always @(negedge mdc) begin
        if (phy_rd && mon_q.size() >= P + 16 && mon_q.size() < P + 32) begin
            phy_oe  = 1'b1;
            phy_bit = phy_data[P + 31 - mon_q.size()];
        end else begin
            phy_oe = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // Clks from command acceptance until STATUS shows busy=0, bounded
    task automatic wait_idle(output int cyc);
        address = A_STATUS;
        cyc = 1;
        @(negedge clk);
        while (readdata[0] !== 1'b0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic build_exp(input logic op_rd, input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] d);
        logic [13:0] h;
        h = {2'b01, op_rd ? 2'b10 : 2'b01, phy, regad};
        exp_q.delete();
        repeat (P) exp_q.push_back(1);
        for (int i = 13; i >= 0; i--) exp_q.push_back(h[i] ? 1 : 0);
        if (op_rd) begin exp_q.push_back(2); exp_q.push_back(2); end
        else       begin exp_q.push_back(1); exp_q.push_back(0); end
        for (int i = 15; i >= 0; i--) exp_q.push_back(d[i] ? 1 : 0);
    endtask

    task automatic check_frame(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= mon_q.size() || mon_q[i] != exp_q[i]) bad++;
        check({tag, "_len"}, mon_q.size(), exp_q.size());
        check({tag, "_badbits"}, bad, 0);
    endtask

    task automatic run_frame(input string tag, input logic op_rd, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [15:0] wd, input logic [15:0] pd);
        logic [31:0] v;
        int c;
        phy_rd = op_rd; phy_data = pd;
        build_exp(op_rd, phy, regad, op_rd ? pd : wd);
        mon_q.delete();
        avm_write(A_CMD, {5'd0, op_rd, phy, regad, wd});
        wait_idle(c);
        check({tag, "_lat"}, (c >= LAT - 1 && c <= LAT + 1) ? LAT : c, LAT);
        if (op_rd) ref_rdata = pd;
        check_frame(tag);
        avm_read(A_STATUS, v);
        check({tag, "_status"}, v, 32'h2);
        avm_read(A_RDATA, v);
        check({tag, "_rdata"}, v, {16'd0, ref_rdata});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_mdc", mdc, 1'b0);
        check("rst_mdio_z", mdio === 1'bz, 1'b1);
        reset_n = 1'b1;
        avm_read(A_STATUS, rd);
        check("rst_status", rd, 32'd0);

        run_frame("wr", 1'b0, 5'd1, 5'd3, 16'h1234, 16'h0);
        run_frame("rd", 1'b1, 5'd2, 5'd2, 16'h0, 16'h0141);

        avm_write(A_STATUS, 32'h2);
        avm_read(A_STATUS, rd);
        check("w1c_status", rd, 32'd0);

        // Second command while busy must be dropped
        phy_rd = 1'b0;
        build_exp(1'b0, 5'd5, 5'd7, 16'hA5C3);
        mon_q.delete();
        avm_write(A_CMD, {5'd0, 1'b0, 5'd5, 5'd7, 16'hA5C3});
        repeat (9) @(negedge clk);
        avm_write(A_CMD, {5'd0, 1'b1, 5'd9, 5'd1, 16'h0});
        wait_idle(lat);
        check_frame("busywr");
        avm_read(A_RDATA, rd);
        check("busywr_rdata", rd, {16'd0, ref_rdata});
        avm_read(A_STATUS, rd);
        check("busywr_status", rd, 32'h2);

        // New command clears done; W1C landing in the completion cycle loses to the set
        avm_write(A_CMD, {5'd0, 1'b0, 5'd3, 5'd4, 16'h0F0F});
        avm_read(A_STATUS, rd);
        check("accept_clears_done", rd, 32'h1);
        repeat (2 * (CD + 1) * N - 3) @(negedge clk);
        avm_write(A_STATUS, 32'h2);
        avm_read(A_STATUS, rd);
        check("w1c_vs_done", rd, 32'h2);

        for (int k = 0; k < 5; k++)
            run_frame($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                      16'($urandom), 16'($urandom));

`ifdef CANDY_AVB_MDIO_IRQ_EN
        avm_write(A_STATUS, 32'h2);
        avm_write(A_IRQ, 32'h1);
        avm_read(A_IRQ, rd);
        check("irq_ctl_rd", rd, 32'h1);
        check("irq_idle", irq, 1'b0);
        run_frame("irqrd", 1'b1, 5'd4, 5'd1, 16'h0, 16'hBEEF);
        check("irq_set", irq, 1'b1);
        avm_write(A_STATUS, 32'h2);
        @(negedge clk);
        check("irq_w1c", irq, 1'b0);
        avm_write(A_IRQ, 32'h0);
        run_frame("irqoff", 1'b1, 5'd6, 5'd2, 16'h0, 16'h1357);
        check("irq_masked", irq, 1'b0);
`else
        avm_write(A_IRQ, 32'hFFFF_FFFF);
        avm_read(A_IRQ, rd);
        check("irq_ctl_absent", rd, 32'd0);
`endif

        // Asynchronous reset in the middle of a preamble
        phy_rd = 1'b0;
        avm_write(A_CMD, {5'd0, 1'b0, 5'd1, 5'd1, 16'hFFFF});
        repeat (100) @(negedge clk);
        check("pre_mdio_driven", mdio === 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mdio_z", mdio === 1'bz, 1'b1);
        check("arst_mdc", mdc, 1'b0);
        check("arst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_read(A_STATUS, rd);
        check("arst_status", rd, 32'd0);
        avm_read(A_RDATA, rd);
        check("arst_rdata", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/candy_avb_mdio_master.md
Name: candy_avb_mdio_master

Overview:
- Avalon-MM slave that serializes IEEE 802.3 Clause 22 MDIO management frames onto one bidirectional pin plus an MDC clock.
- Replaces software bit-banging of the PHY management line through a single-bit bidirectional PIO.
- Sits between the Qsys interconnect (upstream) and the Ethernet PHY pins (downstream).
- CPU writes one command word, polls busy/done, then reads back the 16-bit PHY register value.

Parameters:
- CLK_DIV, 24: MDC half-period in clk cycles is CLK_DIV+1 (50 MHz clk gives 1 MHz MDC); legal range 1..255.
- PREAMBLE_LEN, 32: number of preamble '1' bits sent; legal range 0..32.

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- mdc  out  1  management clock to PHY.
- mdio  inout  1  management data; driven when internal oe=1, otherwise 1'bZ (board pull-up).

Behaviour:
- Register map:
  - 0 CMD (W): [26] op (1=read, 0=write), [25:21] phy_addr, [20:16] reg_addr, [15:0] wdata.
  - 1 STATUS (R): [0] busy, [1] done (sticky). W1C on bit1.
  - 2 RDATA (R): [15:0] last read result, upper bits 0.
  - 3 IRQ_CTL (see Optional Feature); reads 0 when the feature is absent.
- readdata: registered every clk from address, so it is valid one cycle after address is presented; unused bits 0. Reset value 0.
- Other reset values: mdc=0, oe=0 (mdio Z), busy=0, done=0, RDATA=0, state=IDLE.
- A write to CMD while idle latches the command, sets busy=1, clears done, and enters PRE on the next clk. A write to CMD while busy is ignored: no state change, command not latched.
- MDC tick generator:
  - Divider counts 0..CLK_DIV and toggles mdc at terminal count.
  - Counter is held at 0 and mdc held at 0 while IDLE.
  - Falling-edge tick: update output bit. Rising-edge tick: sample mdio.
  - First MDC rising edge occurs CLK_DIV+1 clks after leaving IDLE.
- FSM states, one bit per MDC period; a 6-bit counter selects the bit:
  - PRE: PREAMBLE_LEN bits of '1', oe=1. Skipped when PREAMBLE_LEN=0.
  - HDR: ST=01, OP (10 read / 01 write), PHYAD[4:0], REGAD[4:0]; 14 bits, MSB first, oe=1.
  - TA: write: drive '1','0'. Read: oe=0 for 2 bits.
  - DATA: 16 bits MSB first. Write: drive wdata. Read: oe=0, shift in mdio on each rising edge.
  - DONE: after the last bit's falling edge, oe=0, mdc=0. Load RDATA (read only), busy=0, done=1, then go to IDLE the same cycle.
- Frame length: PREAMBLE_LEN+32 MDC periods. Total latency (CMD write to busy=0): 2*(CLK_DIV+1)*(PREAMBLE_LEN+32)+2 clks ±1.
- A write-op frame leaves RDATA unchanged.
- Done: cleared by W1C or by a new CMD acceptance. If W1C and done-set occur in the same cycle, set wins.
- Asynchronous reset mid-frame: mdio released to Z and mdc=0 immediately; the partial frame is abandoned.

Optional Feature:
- Macro: CANDY_AVB_MDIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - Address 3 bit0 = irq_en (R/W, reset 0).
  - irq = done & irq_en, registered.
- Undefined: no irq port; address 3 reads 0 and writes to it are ignored.

Decomposition:
- Shared package candy_avb_mdio_pkg:
  - State encodings IDLE/PRE/HDR/TA/DATA/DONE.
  - Register offsets CMD/STATUS/RDATA/IRQ_CTL.
  - Opcode constants OP_RD=2'b10, OP_WR=2'b01; ST=2'b01.
- One sub-module: candy_avb_mdio_clkgen (divider, mdc, rise/fall tick pulses).

Test Plan:
- Reset: assert reset_n=0 mid-frame → mdio=Z, mdc=0, readdata=0, STATUS=0 within the same cycle.
- Write frame, CLK_DIV=1, CMD=0x0023_1234 (write, phy 1, reg 3) → 32×'1', then 01 01 00001 00011 10 0x1234 on mdio at MDC rising edges; busy=1 throughout, done=1 afterwards.
- Read frame, CMD=0x0442_0000 (read, phy 2, reg 2), PHY model drives 0x0141 during DATA → mdio Z from TA onward; RDATA=0x0000_0141; STATUS=0x2.
- Busy write: second CMD issued 10 clks after the first → ignored; only one frame on the pins, matching the first command.
- Done handling: write 0x2 to STATUS → done=0. New CMD → done cleared at acceptance. W1C coincident with DONE → done=1.
- CANDY_AVB_MDIO_IRQ_EN: irq_en=1, read frame completes → irq=1 one clk after done. W1C → irq=0. With irq_en=0 → irq stays 0.
